// File: rtl/mem_access_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_access_master                                              |
// | Purpose : Load/store initiator between the execute stage and a           |
// |           byte-addressable data memory. Accepts one request at a time,   |
// |           encodes store width onto mem_WE_o, sign/zero-extends load      |
// |           data and holds the response until the core accepts it.        |
// | Ports   : clk, rst_n           clock, asynchronous active-low reset      |
// |           req_*_i / req_ready_o  core request channel (valid/ready)      |
// |           resp_*_o / resp_ready_i core response channel (valid/ready)    |
// |           mem_WE_o  00 none, 01 word, 10 half, 11 byte                   |
// |           mem_ADDR_o, mem_WD_o  address / write data to memory           |
// |           mem_RD_i  combinational read data for mem_ADDR_o               |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mem_access_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter bit STRICT_ALIGN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [1:0]            mem_WE_o,
  output logic [ADDR_WIDTH-1:0] mem_ADDR_o,
  output logic [31:0]           mem_WD_o,
  input  logic [31:0]           mem_RD_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state_q,  state_d;
  logic                  store_q,  store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [31:0]           wdata_q,  wdata_d;
  logic [31:0]           rdata_q,  rdata_d;
  logic                  err_q,    err_d;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic                  req_err;
  logic [31:0]           load_ext;

  // Request classification on the incoming (not yet registered) fields so
  // an erroneous request can skip the memory cycle entirely.
  always_comb begin
    if (req_store_i) begin
      req_illegal = (req_funct3_i > 3'b010);
    end else begin
      req_illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                    (req_funct3_i == 3'b111);
    end
    // funct3[1:0] gives the access size: 01 half (H/HU/SH), 10 word.
    req_misaligned = STRICT_ALIGN &&
                     (((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                      ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00)));
    req_err = req_illegal || req_misaligned;
  end

  // Load extension: memory presents the addressed byte in RD[7:0].
  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_RD_i[7]}},  mem_RD_i[7:0]};
      3'b001:  load_ext = {{16{mem_RD_i[15]}}, mem_RD_i[15:0]};
      3'b010:  load_ext = mem_RD_i;
      3'b100:  load_ext = {24'h000000, mem_RD_i[7:0]};
      3'b101:  load_ext = {16'h0000,   mem_RD_i[15:0]};
      default: load_ext = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          store_d  = req_store_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        rdata_d = store_q ? 32'h0000_0000 : load_ext;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Write enable is decoded from state (not registered) so an asynchronous
  // reset during ACCESS removes it before the closing edge.
  always_comb begin
    mem_WE_o = 2'b00;
    if ((state_q == S_ACCESS) && store_q) begin
      case (funct3_q[1:0])
        2'b00:   mem_WE_o = 2'b11;
        2'b01:   mem_WE_o = 2'b10;
        2'b10:   mem_WE_o = 2'b01;
        default: mem_WE_o = 2'b00;
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_ADDR_o   = addr_q;
  assign mem_WD_o     = wdata_q;

endmodule
`default_nettype wire
